// File: rtl/id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// id_ex_skid_reg
//
// Decode-to-execute pipeline register built as a two-entry skid buffer.
// MAIN drives the execute-side outputs. SKID catches one extra beat so that
// in_ready depends only on registered state, never on out_ready.
//
// Parameters
//   DATA_W  width of operand data and the sign-extended immediate
//   REG_W   width of register indices
//   CTRL_W  width of the decoded control bundle
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   in_valid / in_ready         decode-side handshake
//   in_rs_data, in_rt_data      register-file read data
//   in_imm                      sign-extended immediate, passed unmodified
//   in_rt, in_rd                destination candidate indices
//   in_ctrl                     decoded control bits
//   flush                       drop every held and incoming beat
//   out_valid / out_ready       execute-side handshake
//   out_*                       registered copies of the input fields
//
// States
//   state | meaning
//   EMPTY | nothing held; out_valid low, out_ctrl forced to zero
//   ONE   | MAIN holds a beat; SKID unused
//   TWO   | MAIN and SKID both hold beats; input stalled
// ---------------------------------------------------------------------------
module id_ex_skid_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [REG_W-1:0]  in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,

    input  logic              flush,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rs_data,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_W-1:0]  out_rt,
    output logic [REG_W-1:0]  out_rd,
    output logic [CTRL_W-1:0] out_ctrl
);

    // All fields travel as one packed beat so MAIN and SKID move together.
    localparam int BEAT_W = 3 * DATA_W + 2 * REG_W + CTRL_W;

    localparam int CTRL_LO = 0;
    localparam int RD_LO   = CTRL_LO + CTRL_W;
    localparam int RT_LO   = RD_LO + REG_W;
    localparam int IMM_LO  = RT_LO + REG_W;
    localparam int RTD_LO  = IMM_LO + DATA_W;
    localparam int RSD_LO  = RTD_LO + DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MAIN_HOLD      = 2'd0,
        MAIN_FROM_IN   = 2'd1,
        MAIN_FROM_SKID = 2'd2
    } main_sel_t;

    state_t      state;
    state_t      state_nxt;
    main_sel_t   main_sel;
    logic        skid_load;

    logic        accept;
    logic        consume;

    logic [BEAT_W-1:0] in_beat;
    logic [BEAT_W-1:0] main_beat;
    logic [BEAT_W-1:0] skid_beat;

    assign in_beat = {in_rs_data, in_rt_data, in_imm, in_rt, in_rd, in_ctrl};

    // Handshake flags come straight from registered state.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);

    assign accept  = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and entry-load controls
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        main_sel  = MAIN_HOLD;
        skid_load = 1'b0;

        if (flush) begin
            // Flush wins over any accept or consume in the same cycle; the
            // entries keep their old contents, only validity is dropped.
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        main_sel  = MAIN_FROM_IN;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        state_nxt = ONE;
                        main_sel  = MAIN_FROM_IN;
                    end else if (accept) begin
                        state_nxt = TWO;
                        skid_load = 1'b1;
                    end else if (consume) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so accept cannot occur.
                    if (consume) begin
                        state_nxt = ONE;
                        main_sel  = MAIN_FROM_SKID;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Storage entries
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            main_beat <= '0;
            skid_beat <= '0;
        end else begin
            unique case (main_sel)
                MAIN_FROM_IN:   main_beat <= in_beat;
                MAIN_FROM_SKID: main_beat <= skid_beat;
                default:        main_beat <= main_beat;
            endcase
            if (skid_load) begin
                skid_beat <= in_beat;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_rs_data = main_beat[RSD_LO +: DATA_W];
    assign out_rt_data = main_beat[RTD_LO +: DATA_W];
    assign out_imm     = main_beat[IMM_LO +: DATA_W];
    assign out_rt      = main_beat[RT_LO  +: REG_W];
    assign out_rd      = main_beat[RD_LO  +: REG_W];

    // A bubble must not cause a register write or memory access, so the
    // control bundle is masked whenever nothing valid is presented.
    assign out_ctrl = out_valid ? main_beat[CTRL_LO +: CTRL_W] : '0;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_skid_reg
//
// Directed bench for id_ex_skid_reg. Every beat's fields are derived from its
// immediate value so that each output field can be predicted independently.
// ---------------------------------------------------------------------------
module tb_id_ex_skid_reg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 8;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_rs_data;
    logic [DATA_W-1:0] in_rt_data;
    logic [DATA_W-1:0] in_imm;
    logic [REG_W-1:0]  in_rt;
    logic [REG_W-1:0]  in_rd;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_rs_data;
    logic [DATA_W-1:0] out_rt_data;
    logic [DATA_W-1:0] out_imm;
    logic [REG_W-1:0]  out_rt;
    logic [REG_W-1:0]  out_rd;
    logic [CTRL_W-1:0] out_ctrl;

    int checks;
    int fails;

    id_ex_skid_reg #(
        .DATA_W (DATA_W),
        .REG_W  (REG_W),
        .CTRL_W (CTRL_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs_data  (in_rs_data),
        .in_rt_data  (in_rt_data),
        .in_imm      (in_imm),
        .in_rt       (in_rt),
        .in_rd       (in_rd),
        .in_ctrl     (in_ctrl),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs_data (out_rs_data),
        .out_rt_data (out_rt_data),
        .out_imm     (out_imm),
        .out_rt      (out_rt),
        .out_rd      (out_rd),
        .out_ctrl    (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field derivation from the immediate (stimulus and expectation both).
    function automatic logic [DATA_W-1:0] rs_of(input logic [DATA_W-1:0] imm);
        return imm ^ 32'hA5A5_5A5A;
    endfunction
    function automatic logic [DATA_W-1:0] rtd_of(input logic [DATA_W-1:0] imm);
        return {imm[15:0], imm[31:16]};
    endfunction
    function automatic logic [REG_W-1:0] rt_of(input logic [DATA_W-1:0] imm);
        return imm[4:0] ^ 5'h0A;
    endfunction
    function automatic logic [REG_W-1:0] rd_of(input logic [DATA_W-1:0] imm);
        return imm[9:5] ^ 5'h13;
    endfunction
    function automatic logic [CTRL_W-1:0] ctrl_of(input logic [DATA_W-1:0] imm);
        return imm[7:0] ^ 8'h3C;
    endfunction

    // Advance one clock; sampling happens 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [DATA_W-1:0] imm);
        in_valid   = 1'b1;
        in_imm     = imm;
        in_rs_data = rs_of(imm);
        in_rt_data = rtd_of(imm);
        in_rt      = rt_of(imm);
        in_rd      = rd_of(imm);
        in_ctrl    = ctrl_of(imm);
    endtask

    task automatic idle();
        in_valid   = 1'b0;
        in_imm     = 32'hDEAD_BEEF;
        in_rs_data = 32'h1234_5678;
        in_rt_data = 32'h8765_4321;
        in_rt      = 5'h1F;
        in_rd      = 5'h1F;
        in_ctrl    = 8'hFF;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        offer(32'h0000_1111);
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if ({out_rs_data, out_rt_data, out_imm, out_rt, out_rd, out_ctrl} !== '0) begin
            fails++;
            $display("FAIL reset_outputs_zero: imm %h rs %h rtd %h rt %h rd %h ctrl %h expected all zero",
                     out_imm, out_rs_data, out_rt_data, out_rt, out_rd, out_ctrl);
        end
        reset = 1'b0;
        idle();
        step();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_streaming();
        logic [DATA_W-1:0] vals [4];
        vals[0] = 32'h0000_7FFF;
        vals[1] = 32'hFFFF_FDFF;
        vals[2] = 32'h0000_0000;
        vals[3] = 32'hFFFF_8000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(vals[i]);
            checks++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready);
            end
            step();
            checks++;
            if (out_valid !== 1'b1 || out_imm !== vals[i]) begin
                fails++;
                $display("FAIL stream_imm[%0d]: got valid %b imm %h expected valid 1 imm %h",
                         i, out_valid, out_imm, vals[i]);
            end
            checks++;
            if (out_rs_data !== rs_of(vals[i]) || out_rt_data !== rtd_of(vals[i]) ||
                out_rt !== rt_of(vals[i]) || out_rd !== rd_of(vals[i]) ||
                out_ctrl !== ctrl_of(vals[i])) begin
                fails++;
                $display("FAIL stream_fields[%0d]: got rs %h rtd %h rt %h rd %h ctrl %h expected rs %h rtd %h rt %h rd %h ctrl %h",
                         i, out_rs_data, out_rt_data, out_rt, out_rd, out_ctrl,
                         rs_of(vals[i]), rtd_of(vals[i]), rt_of(vals[i]), rd_of(vals[i]), ctrl_of(vals[i]));
            end
        end
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
            fails++;
            $display("FAIL stream_drain: got valid %b ctrl %h expected valid 0 ctrl 00", out_valid, out_ctrl);
        end
        checks++;
        if (out_imm !== 32'hFFFF_8000) begin
            fails++;
            $display("FAIL stream_hold_imm: got %h expected ffff8000", out_imm);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_backpressure();
        out_ready = 1'b0;
        offer(32'h0000_0101);
        step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_imm !== 32'h0000_0101) begin
            fails++;
            $display("FAIL bp_first: got valid %b ready %b imm %h expected 1 1 00000101",
                     out_valid, in_ready, out_imm);
        end
        offer(32'h0000_0202);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_imm !== 32'h0000_0101 || out_ctrl !== ctrl_of(32'h0000_0101)) begin
            fails++;
            $display("FAIL bp_two: got ready %b imm %h ctrl %h expected 0 00000101 %h",
                     in_ready, out_imm, out_ctrl, ctrl_of(32'h0000_0101));
        end
        offer(32'h0000_0303);
        step();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'h0000_0101 ||
            out_rs_data !== rs_of(32'h0000_0101)) begin
            fails++;
            $display("FAIL bp_frozen: got ready %b valid %b imm %h rs %h expected 0 1 00000101 %h",
                     in_ready, out_valid, out_imm, out_rs_data, rs_of(32'h0000_0101));
        end
        // Release: beat 1 leaves, SKID (beat 2) moves to MAIN; beat 3 still waiting.
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'h0000_0202 || in_ready !== 1'b1 ||
            out_rd !== rd_of(32'h0000_0202)) begin
            fails++;
            $display("FAIL bp_second: got valid %b imm %h ready %b rd %h expected 1 00000202 1 %h",
                     out_valid, out_imm, in_ready, out_rd, rd_of(32'h0000_0202));
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'h0000_0303) begin
            fails++;
            $display("FAIL bp_third: got valid %b imm %h expected 1 00000303", out_valid, out_imm);
        end
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: got valid %b expected 0", out_valid);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_simultaneous();
        out_ready = 1'b0;
        offer(32'h0000_0A0A);
        step();
        out_ready = 1'b1;
        offer(32'h0000_0B0B);
        step();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_imm !== 32'h0000_0B0B ||
            out_rt !== rt_of(32'h0000_0B0B)) begin
            fails++;
            $display("FAIL simul_update: got valid %b ready %b imm %h rt %h expected 1 1 00000b0b %h",
                     out_valid, in_ready, out_imm, out_rt, rt_of(32'h0000_0B0B));
        end
        // Still in ONE: one consume with no accept empties the buffer.
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL simul_one_state: got valid %b expected 0", out_valid);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_flush();
        out_ready = 1'b0;
        offer(32'h0000_1001);
        step();
        offer(32'h0000_1002);
        step();
        offer(32'h0000_1003);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_state: got valid %b ctrl %h ready %b expected 0 00 1",
                     out_valid, out_ctrl, in_ready);
        end
        idle();
        out_ready = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_discard: got valid %b imm %h expected valid 0", out_valid, out_imm);
        end
        // Flush in ONE together with an offered and a consumed beat.
        out_ready = 1'b0;
        offer(32'h0000_2001);
        step();
        out_ready = 1'b1;
        offer(32'h0000_2002);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        checks++;
        if (out_valid !== 1'b0 || out_ctrl !== 8'h00) begin
            fails++;
            $display("FAIL flush_one: got valid %b ctrl %h expected 0 00", out_valid, out_ctrl);
        end
        offer(32'h0000_2003);
        step();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'h0000_2003) begin
            fails++;
            $display("FAIL flush_recover: got valid %b imm %h expected 1 00002003", out_valid, out_imm);
        end
        step();
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_midstream();
        out_ready = 1'b0;
        offer(32'h0000_3001);
        step();
        offer(32'h0000_3002);
        step();
        offer(32'h0000_3003);
        flush = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {out_rs_data, out_rt_data, out_imm, out_rt, out_rd, out_ctrl} !== '0) begin
            fails++;
            $display("FAIL reset_mid: got valid %b ready %b imm %h rs %h ctrl %h expected 0 1 and all zero",
                     out_valid, in_ready, out_imm, out_rs_data, out_ctrl);
        end
        out_ready = 1'b1;
        offer(32'hFFFF_8001);
        step();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_imm !== 32'hFFFF_8001 || out_rs_data !== rs_of(32'hFFFF_8001) ||
            out_rt_data !== rtd_of(32'hFFFF_8001) || out_ctrl !== ctrl_of(32'hFFFF_8001)) begin
            fails++;
            $display("FAIL reset_mid_new: got valid %b imm %h rs %h rtd %h ctrl %h expected 1 ffff8001 %h %h %h",
                     out_valid, out_imm, out_rs_data, out_rt_data, out_ctrl,
                     rs_of(32'hFFFF_8001), rtd_of(32'hFFFF_8001), ctrl_of(32'hFFFF_8001));
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_drain: got valid %b expected 0", out_valid);
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        checks = 0;
        fails  = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();

        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_reset_midstream();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
